// File: rtl/stencil_feeder_pkg.sv
// Shared types and default sizing for the stencil stream feeder.
// Optional counting-ramp source is enabled by defining STENCIL_FEEDER_RAMP_EN.
package stencil_feeder_pkg;

   localparam int DEFAULT_WIDTH = 16;
   localparam int DEFAULT_DEPTH = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DONE   = 2'd2
   } state_e;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/stencil_stream_feeder_if.sv
// Host push handshake and accelerator read port of the stencil stream feeder.
// master = producer/consumer side, slave = feeder side.
interface stencil_stream_feeder_if
   import stencil_feeder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);
   logic             host_valid;
   logic [WIDTH-1:0] host_data;
   logic             host_ready;
   logic             read_en;
   logic [WIDTH-1:0] read_data;

   modport master (
      output host_valid, host_data, read_en,
      input  host_ready, read_data
   );

   modport slave (
      input  host_valid, host_data, read_en,
      output host_ready, read_data
   );
endinterface

// File: rtl/stencil_feeder_fifo.sv
// DEPTH-entry circular buffer behind the feeder's head register.
// Pointers wrap naturally because DEPTH is a power of two.
module stencil_feeder_fifo
   import stencil_feeder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DEPTH = DEFAULT_DEPTH,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_data_o,
   output logic             empty_o,
   output logic             full_o,
   output logic [AW:0]      count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic             push_ok;
   logic             pop_ok;

   assign empty_o     = (count_q == '0);
   assign full_o      = (count_q == (AW+1)'(DEPTH));
   assign count_o     = count_q;
   assign push_ok     = push_i && !full_o;
   assign pop_ok      = pop_i && !empty_o;
   assign head_data_o = mem_q[rd_ptr_q];

   // Storage carries no reset so it maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop_ok) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/stencil_stream_feeder.sv
// Frames a host word stream into counted bursts for an accelerator, via FIFO + head register.
// Define STENCIL_FEEDER_RAMP_EN to add ramp_sel, a FIFO-bypassing 0,1,2,... test source.
module stencil_stream_feeder
   import stencil_feeder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   start,
   input  logic [15:0]            cfg_num_words,
`ifdef STENCIL_FEEDER_RAMP_EN
   input  logic                   ramp_sel,
`endif
   stencil_stream_feeder_if.slave bus,
   output logic                   busy,
   output logic                   done,
   output logic                   underflow,
   output logic [15:0]            words_sent
);

   localparam int AW = $clog2(DEPTH);

   state_e           state_q, state_d;
   logic [15:0]      num_q, num_d;
   logic [15:0]      sent_q, sent_d;
   logic             under_q, under_d;
   logic [WIDTH-1:0] head_q, head_d;
   logic             head_valid_q, head_valid_d;

   logic             fifo_push, fifo_pop, fifo_empty, fifo_full_raw, fifo_full;
   logic [WIDTH-1:0] fifo_head;
   logic [AW:0]      fifo_count;
   logic             ramp_act, avail, in_stream, rd_req, consume;
   logic [15:0]      sent_inc;

`ifdef STENCIL_FEEDER_RAMP_EN
   logic             ramp_q, ramp_d;
   logic [WIDTH-1:0] ramp_cnt_q, ramp_cnt_d;
   assign ramp_act      = ramp_q;
   assign bus.read_data = ramp_q ? ramp_cnt_q : head_q;
`else
   assign ramp_act      = 1'b0;
   assign bus.read_data = head_q;
`endif

   // The head register counts toward capacity, so total buffered words never exceed DEPTH.
   assign fifo_full      = fifo_full_raw || (head_valid_q && (fifo_count == (AW+1)'(DEPTH-1)));
   assign bus.host_ready = !fifo_full;
   assign fifo_push      = bus.host_valid && !fifo_full;
   assign in_stream      = (state_q == ST_STREAM);
   assign avail          = ramp_act || head_valid_q;
   assign rd_req         = in_stream && bus.read_en && !flush;
   assign consume        = rd_req && avail;
   assign fifo_pop       = !ramp_act && !fifo_empty && (!head_valid_q || consume);
   assign sent_inc       = sat_inc16(sent_q);

   stencil_feeder_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (fifo_push),
      .push_data_i (bus.host_data),
      .pop_i       (fifo_pop),
      .head_data_o (fifo_head),
      .empty_o     (fifo_empty),
      .full_o      (fifo_full_raw),
      .count_o     (fifo_count)
   );

   always_comb begin
      head_d       = head_q;
      head_valid_d = head_valid_q;
      if (fifo_pop) begin
         head_d       = fifo_head;
         head_valid_d = 1'b1;
      end else if (consume && !ramp_act) begin
         head_valid_d = 1'b0;
      end
   end

   always_comb begin
      state_d = state_q;
      num_d   = num_q;
      sent_d  = sent_q;
      under_d = under_q;
`ifdef STENCIL_FEEDER_RAMP_EN
      ramp_d     = ramp_q;
      ramp_cnt_d = ramp_cnt_q;
`endif
      if (flush) begin
         state_d = ST_IDLE;
         sent_d  = '0;
         under_d = 1'b0;
`ifdef STENCIL_FEEDER_RAMP_EN
         ramp_d  = 1'b0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  num_d   = cfg_num_words;
                  sent_d  = '0;
                  state_d = (cfg_num_words == 16'd0) ? ST_DONE : ST_STREAM;
`ifdef STENCIL_FEEDER_RAMP_EN
                  ramp_d     = ramp_sel;
                  ramp_cnt_d = '0;
`endif
               end
            end
            ST_STREAM: begin
               if (consume) begin
                  sent_d = sent_inc;
`ifdef STENCIL_FEEDER_RAMP_EN
                  if (ramp_q) begin
                     ramp_cnt_d = ramp_cnt_q + WIDTH'(1);
                  end
`endif
                  if (sent_inc == num_q) begin
                     state_d = ST_DONE;
                  end
               end else if (rd_req) begin
                  under_d = 1'b1;
               end
            end
            ST_DONE: begin
               state_d = ST_IDLE;
`ifdef STENCIL_FEEDER_RAMP_EN
               ramp_d  = 1'b0;
`endif
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         num_q        <= '0;
         sent_q       <= '0;
         under_q      <= 1'b0;
         head_q       <= '0;
         head_valid_q <= 1'b0;
`ifdef STENCIL_FEEDER_RAMP_EN
         ramp_q       <= 1'b0;
         ramp_cnt_q   <= '0;
`endif
      end else begin
         state_q      <= state_d;
         num_q        <= num_d;
         sent_q       <= sent_d;
         under_q      <= under_d;
         head_q       <= head_d;
         head_valid_q <= head_valid_d;
`ifdef STENCIL_FEEDER_RAMP_EN
         ramp_q       <= ramp_d;
         ramp_cnt_q   <= ramp_cnt_d;
`endif
      end
   end

   assign busy       = in_stream;
   assign done       = (state_q == ST_DONE);
   assign underflow  = under_q;
   assign words_sent = sent_q;

endmodule

// File: tb/tb_stencil_stream_feeder.sv
// Self-checking bench: per-cycle vector table, hand-written corner sequences,
// and a randomized run against a queue-based reference model.
module tb_stencil_stream_feeder;
   import stencil_feeder_pkg::*;

   localparam int WIDTH = DEFAULT_WIDTH;
   localparam int DEPTH = DEFAULT_DEPTH;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        start;
   logic [15:0] cfg_num_words;
`ifdef STENCIL_FEEDER_RAMP_EN
   logic        ramp_sel;
`endif
   logic        busy;
   logic        done;
   logic        underflow;
   logic [15:0] words_sent;

   stencil_stream_feeder_if #(.WIDTH(WIDTH)) bus ();

   stencil_stream_feeder #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .flush         (flush),
      .start         (start),
      .cfg_num_words (cfg_num_words),
`ifdef STENCIL_FEEDER_RAMP_EN
      .ramp_sel      (ramp_sel),
`endif
      .bus           (bus.slave),
      .busy          (busy),
      .done          (done),
      .underflow     (underflow),
      .words_sent    (words_sent)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic        hv;
      logic [15:0] hd;
      logic        st;
      logic [15:0] cfg;
      logic        ren;
      logic        fl;
      logic [15:0] rd;
      logic        bsy;
      logic        dn;
      logic [15:0] sent;
      logic        rdy;
      logic        und;
   } vec_t;

   typedef struct {
      logic [15:0] d;
      int          t;
   } word_t;

   vec_t        vt [24];
   word_t       mq [$];
   word_t       w;
   int          acc;
   logic        take;
   int          e_idx;
   int          m_state;
   logic [15:0] m_num, m_sent, m_rd;
   logic        m_und, m_push, m_cons_ok, slow;

   function automatic vec_t mk(input int hv, input int hd, input int st, input int cfg,
                               input int ren, input int fl, input int rd, input int bsy,
                               input int dn, input int sent, input int rdy, input int und);
      vec_t v;
      v.hv = hv[0];   v.hd = hd[15:0];  v.st = st[0];    v.cfg = cfg[15:0];
      v.ren = ren[0]; v.fl = fl[0];     v.rd = rd[15:0]; v.bsy = bsy[0];
      v.dn = dn[0];   v.sent = sent[15:0]; v.rdy = rdy[0]; v.und = und[0];
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      rst            = 1'b0;
      flush          = 1'b0;
      start          = 1'b0;
      cfg_num_words  = '0;
      bus.host_valid = 1'b0;
      bus.host_data  = '0;
      bus.read_en    = 1'b0;
`ifdef STENCIL_FEEDER_RAMP_EN
      ramp_sel       = 1'b0;
`endif
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // hv hd st cfg ren fl | rd bsy dn sent rdy und
      vt[0]  = mk(1, 1, 0,0,0,0,  0,0,0,0,1,0);
      vt[1]  = mk(1, 2, 0,0,0,0,  1,0,0,0,1,0);
      vt[2]  = mk(1, 3, 0,0,0,0,  1,0,0,0,1,0);
      vt[3]  = mk(1, 4, 0,0,0,0,  1,0,0,0,1,0);
      vt[4]  = mk(0, 0, 1,4,0,0,  1,1,0,0,1,0);
      vt[5]  = mk(0, 0, 0,0,1,0,  2,1,0,1,1,0);
      vt[6]  = mk(0, 0, 0,0,1,0,  3,1,0,2,1,0);
      vt[7]  = mk(0, 0, 0,0,1,0,  4,1,0,3,1,0);
      vt[8]  = mk(0, 0, 0,0,1,0,  4,0,1,4,1,0);
      vt[9]  = mk(0, 0, 0,0,1,0,  4,0,0,4,1,0);
      vt[10] = mk(0, 0, 0,0,1,0,  4,0,0,4,1,0);
      vt[11] = mk(0, 0, 1,3,0,0,  4,1,0,0,1,0);
      vt[12] = mk(1,10, 0,0,0,0,  4,1,0,0,1,0);
      vt[13] = mk(1,11, 0,0,0,0, 10,1,0,0,1,0);
      vt[14] = mk(0, 0, 0,0,1,0, 11,1,0,1,1,0);
      vt[15] = mk(0, 0, 0,0,1,0, 11,1,0,2,1,0);
      vt[16] = mk(0, 0, 0,0,1,0, 11,1,0,2,1,1);
      vt[17] = mk(1,12, 0,0,1,0, 11,1,0,2,1,1);
      vt[18] = mk(0, 0, 0,0,1,0, 12,1,0,2,1,1);
      vt[19] = mk(0, 0, 0,0,1,0, 12,0,1,3,1,1);
      vt[20] = mk(0, 0, 0,0,0,0, 12,0,0,3,1,1);
      vt[21] = mk(0, 0, 1,0,0,0, 12,0,1,0,1,1);
      vt[22] = mk(0, 0, 0,0,0,0, 12,0,0,0,1,1);
      vt[23] = mk(0, 0, 0,0,0,1, 12,0,0,0,1,0);

      // Reset state
      do_reset();
      check("rst.read_data", bus.read_data, 0);
      check("rst.host_ready", bus.host_ready, 1);
      check("rst.busy", busy, 0);
      check("rst.done", done, 0);
      check("rst.underflow", underflow, 0);
      check("rst.words_sent", words_sent, 0);

      // Per-cycle vectors: basic frame, underflow recovery, zero-length frame, flush
      for (int i = 0; i < 24; i++) begin
         bus.host_valid = vt[i].hv;
         bus.host_data  = vt[i].hd;
         start          = vt[i].st;
         cfg_num_words  = vt[i].cfg;
         bus.read_en    = vt[i].ren;
         flush          = vt[i].fl;
         tick();
         $display("[TB] vec %0d rd=%0h busy=%0b done=%0b sent=%0d ready=%0b und=%0b",
                  i, bus.read_data, busy, done, words_sent, bus.host_ready, underflow);
         check($sformatf("vec%0d.read_data", i), bus.read_data, vt[i].rd);
         check($sformatf("vec%0d.busy", i), busy, vt[i].bsy);
         check($sformatf("vec%0d.done", i), done, vt[i].dn);
         check($sformatf("vec%0d.words_sent", i), words_sent, vt[i].sent);
         check($sformatf("vec%0d.host_ready", i), bus.host_ready, vt[i].rdy);
         check($sformatf("vec%0d.underflow", i), underflow, vt[i].und);
      end
      idle_inputs();

      // Fill past capacity: only DEPTH words accepted until a consume frees a slot
      do_reset();
      acc = 0;
      bus.host_valid = 1'b1;
      bus.host_data  = 16'd100;
      for (int c = 0; c < 24; c++) begin
         take = bus.host_ready;
         tick();
         if (take) begin
            acc++;
            bus.host_data = 16'(100 + acc);
         end
      end
      $display("[TB] fill accepted=%0d ready=%0b", acc, bus.host_ready);
      check("fill.accepted", acc, DEPTH);
      check("fill.ready_low", bus.host_ready, 0);
      start = 1'b1;
      cfg_num_words = 16'd17;
      tick();
      start = 1'b0;
      check("fill.busy", busy, 1);
      check("fill.still_full", bus.host_ready, 0);
      bus.read_en = 1'b1;
      check("fill.first_word", bus.read_data, 100);
      tick();
      bus.read_en = 1'b0;
      check("fill.ready_after_consume", bus.host_ready, 1);
      tick();
      bus.host_valid = 1'b0;
      check("fill.sent_one", words_sent, 1);
      bus.read_en = 1'b1;
      for (int i = 0; i < 16; i++) begin
         $display("[TB] fill consume %0d rd=%0d", i + 1, bus.read_data);
         check($sformatf("fill.word%0d", i + 1), bus.read_data, 101 + i);
         tick();
      end
      bus.read_en = 1'b0;
      check("fill.done", done, 1);
      check("fill.words_sent", words_sent, 17);
      idle_inputs();

      // Flush mid-frame keeps buffered words for the next frame
      do_reset();
      bus.host_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         bus.host_data = 16'(200 + i);
         tick();
      end
      bus.host_valid = 1'b0;
      tick();
      start = 1'b1;
      cfg_num_words = 16'd5;
      tick();
      start = 1'b0;
      bus.read_en = 1'b1;
      for (int i = 0; i < 2; i++) begin
         check($sformatf("flush.pre%0d", i), bus.read_data, 200 + i);
         tick();
      end
      bus.read_en = 1'b0;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      $display("[TB] flush busy=%0b sent=%0d rd=%0d", busy, words_sent, bus.read_data);
      check("flush.busy", busy, 0);
      check("flush.words_sent", words_sent, 0);
      check("flush.head_kept", bus.read_data, 202);
      start = 1'b1;
      cfg_num_words = 16'd3;
      tick();
      start = 1'b0;
      bus.read_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("flush.post%0d", i), bus.read_data, 202 + i);
         tick();
      end
      bus.read_en = 1'b0;
      check("flush.done", done, 1);
      check("flush.words_sent_end", words_sent, 3);
      idle_inputs();

`ifdef STENCIL_FEEDER_RAMP_EN
      // Ramp source bypasses the FIFO; buffered words survive it
      do_reset();
      bus.host_valid = 1'b1;
      bus.host_data  = 16'd300;
      tick();
      bus.host_data  = 16'd301;
      tick();
      bus.host_valid = 1'b0;
      tick();
      ramp_sel = 1'b1;
      start = 1'b1;
      cfg_num_words = 16'd5;
      tick();
      start = 1'b0;
      ramp_sel = 1'b0;
      bus.read_en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check($sformatf("ramp.word%0d", i), bus.read_data, i);
         tick();
      end
      bus.read_en = 1'b0;
      check("ramp.done", done, 1);
      check("ramp.underflow", underflow, 0);
      tick();
      check("ramp.fifo_head", bus.read_data, 300);
      start = 1'b1;
      cfg_num_words = 16'd2;
      tick();
      start = 1'b0;
      bus.read_en = 1'b1;
      check("ramp.after0", bus.read_data, 300);
      tick();
      check("ramp.after1", bus.read_data, 301);
      tick();
      bus.read_en = 1'b0;
      check("ramp.after_done", done, 1);
      idle_inputs();
`endif

      // Randomized traffic against a queue model of total buffered words
      do_reset();
      mq.delete();
      e_idx   = 0;
      m_state = 0;
      m_num   = '0;
      m_sent  = '0;
      m_rd    = '0;
      m_und   = 1'b0;
      for (int it = 0; it < 3000; it++) begin
         slow           = ((it / 250) % 2) == 1;
         rst            = ($urandom_range(0, 299) == 0);
         flush          = ($urandom_range(0, 59) == 0);
         start          = ($urandom_range(0, 7) == 0);
         cfg_num_words  = 16'($urandom_range(0, 6));
         bus.host_valid = ($urandom_range(0, 3) != 0);
         bus.host_data  = 16'($urandom);
         bus.read_en    = slow ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         check("rnd.host_ready", bus.host_ready, (mq.size() < DEPTH));
         m_push = bus.host_valid && (mq.size() < DEPTH);
         w.d = bus.host_data;
         tick();
         e_idx++;
         w.t = e_idx;
         if (rst) begin
            mq.delete();
            m_state = 0;
            m_num   = '0;
            m_sent  = '0;
            m_rd    = '0;
            m_und   = 1'b0;
         end else begin
            // A word is consumable two edges after it was pushed
            m_cons_ok = (mq.size() > 0) && (mq[0].t <= e_idx - 2);
            if (flush) begin
               m_state = 0;
               m_sent  = '0;
               m_und   = 1'b0;
            end else begin
               case (m_state)
                  0: if (start) begin
                        m_num   = cfg_num_words;
                        m_sent  = '0;
                        m_state = (cfg_num_words == 0) ? 2 : 1;
                     end
                  1: if (bus.read_en) begin
                        if (m_cons_ok) begin
                           void'(mq.pop_front());
                           if (m_sent != 16'hFFFF) m_sent = m_sent + 16'd1;
                           if (m_sent == m_num) m_state = 2;
                        end else begin
                           m_und = 1'b1;
                        end
                     end
                  default: m_state = 0;
               endcase
            end
            if (m_push) mq.push_back(w);
            if ((mq.size() > 0) && (mq[0].t <= e_idx - 1)) m_rd = mq[0].d;
         end
         check("rnd.read_data", bus.read_data, m_rd);
         check("rnd.busy", busy, (m_state == 1));
         check("rnd.done", done, (m_state == 2));
         check("rnd.words_sent", words_sent, m_sent);
         check("rnd.underflow", underflow, m_und);
      end
      idle_inputs();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
